// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and defaults for the SDRAM port arbiter.
//   arb_state_e     - arbiter FSM states (idle, command issue, wait for completion)
//   arb_owner_e     - which requester currently owns the memory port
//   BurstLenDefault - default number of 32-bit beats in a video burst read
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCmd  = 2'd1,
    StWait = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnVid  = 2'd1,
    OwnCpu  = 2'd2
  } arb_owner_e;

  localparam int unsigned BurstLenDefault = 8;

endpackage

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller port between a video burst
// reader and a CPU single-word port.
//   clk, reset_i                      - single clock, synchronous active-high reset
//   vid_req_i / vid_addr_i            - video burst read request and start address
//   vid_valid_o / vid_data_o          - forwarded read beats (combinational from memory)
//   vid_last_o / vid_done_o           - final-beat flag, completion pulse
//   cpu_req_i / cpu_we_i / cpu_addr_i / cpu_wdata_i / cpu_be_i - CPU single-word access
//   cpu_rdata_o / cpu_ack_o           - captured CPU read data, completion pulse
//   mem_req_o .. mem_be_o             - registered command toward the controller
//   mem_ack_i / mem_rvalid_i / mem_rdata_i / mem_done_i - controller responses
// Video wins simultaneous requests until it has taken VID_MAX_CONSEC grants in a
// row while the CPU was waiting; then the CPU gets the next grant.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 24,
  parameter int unsigned BURST_LEN      = BurstLenDefault,
  parameter int unsigned VID_MAX_CONSEC = 3
) (
  input  logic              clk,
  input  logic              reset_i,
  // video port
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_valid_o,
  output logic [31:0]       vid_data_o,
  output logic              vid_last_o,
  output logic              vid_done_o,
  // cpu port
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  input  logic [3:0]        cpu_be_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_ack_o,
  // controller port
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic              mem_burst_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_ack_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_done_i
);

  localparam int unsigned BeatW  = $clog2(BURST_LEN + 1);
  localparam int unsigned StarvW = (VID_MAX_CONSEC > 0) ? $clog2(VID_MAX_CONSEC + 1) : 1;

  localparam logic [BeatW-1:0]  LastBeat  = BeatW'(BURST_LEN - 1);
  localparam logic [BeatW-1:0]  BeatsDone = BeatW'(BURST_LEN);
  localparam logic [StarvW-1:0] StarvMax  = StarvW'(VID_MAX_CONSEC);

  arb_state_e        r_state;
  arb_owner_e        r_owner;
  logic [StarvW-1:0] r_starv;
  logic [BeatW-1:0]  r_beat;
  logic              r_done_pend;
  logic              r_vid_done;
  logic              r_cpu_ack;
  logic [31:0]       r_cpu_rdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic              r_mem_burst;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_be;

  logic w_grant_vid;
  logic w_grant_cpu;
  logic w_vid_fwd;
  logic w_cpu_capture;

  // Video has priority unless the CPU has been starved for the full allowance.
  assign w_grant_vid = vid_req_i && !(cpu_req_i && (r_starv == StarvMax));
  assign w_grant_cpu = cpu_req_i && !w_grant_vid;

  // Read beats only count in WAIT; beats past the burst length are dropped.
  assign w_vid_fwd     = (r_state == StWait) && (r_owner == OwnVid) && mem_rvalid_i &&
                         (r_beat != BeatsDone);
  assign w_cpu_capture = (r_state == StWait) && (r_owner == OwnCpu) && mem_rvalid_i &&
                         !r_mem_we;

  assign vid_valid_o = w_vid_fwd;
  assign vid_data_o  = mem_rdata_i;
  assign vid_last_o  = w_vid_fwd && (r_beat == LastBeat);
  assign vid_done_o  = r_vid_done;
  assign cpu_ack_o   = r_cpu_ack;
  assign cpu_rdata_o = r_cpu_rdata;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_burst_o = r_mem_burst;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_be_o    = r_mem_be;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state     <= StIdle;
      r_owner     <= OwnNone;
      r_starv     <= '0;
      r_beat      <= '0;
      r_done_pend <= 1'b0;
      r_vid_done  <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_burst <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      r_vid_done <= 1'b0;
      r_cpu_ack  <= 1'b0;

      if (w_cpu_capture) begin
        r_cpu_rdata <= mem_rdata_i;
      end
      if (w_vid_fwd) begin
        r_beat <= r_beat + BeatW'(1);
      end

      unique case (r_state)
        StIdle: begin
          r_done_pend <= 1'b0;
          if (w_grant_vid) begin
            r_owner     <= OwnVid;
            r_state     <= StCmd;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_burst <= 1'b1;
            r_mem_addr  <= vid_addr_i;
            r_mem_wdata <= '0;
            r_mem_be    <= 4'hF;
            r_beat      <= '0;
            // Only count grants that actually made the CPU wait.
            if (!cpu_req_i) begin
              r_starv <= '0;
            end else if (r_starv != StarvMax) begin
              r_starv <= r_starv + StarvW'(1);
            end
          end else if (w_grant_cpu) begin
            r_owner     <= OwnCpu;
            r_state     <= StCmd;
            r_mem_req   <= 1'b1;
            r_mem_we    <= cpu_we_i;
            r_mem_burst <= 1'b0;
            r_mem_addr  <= cpu_addr_i;
            r_mem_wdata <= cpu_wdata_i;
            r_mem_be    <= cpu_be_i;
            r_starv     <= '0;
          end
        end

        StCmd: begin
          if (mem_ack_i) begin
            r_mem_req   <= 1'b0;
            r_state     <= StWait;
            // Done arriving with ack completes one cycle later from WAIT.
            r_done_pend <= mem_done_i;
          end
        end

        StWait: begin
          if (mem_done_i || r_done_pend) begin
            r_done_pend <= 1'b0;
            r_state     <= StIdle;
            r_owner     <= OwnNone;
            if (r_owner == OwnVid) begin
              r_vid_done <= 1'b1;
            end else if (r_owner == OwnCpu) begin
              r_cpu_ack <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= StIdle;
          r_owner <= OwnNone;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: self-checking bench for sdram_port_arbiter. Expected
// commands and video beats are queued as stimulus is driven and popped when the
// DUT issues a command or forwards a beat.
module tb_sdram_port_arbiter;

  localparam int unsigned ADDR_W         = 24;
  localparam int unsigned BURST_LEN      = 8;
  localparam int unsigned VID_MAX_CONSEC = 3;

  typedef struct packed {
    logic              we;
    logic              burst;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
  } cmd_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              vid_req_i;
  logic [ADDR_W-1:0] vid_addr_i;
  logic              vid_valid_o;
  logic [31:0]       vid_data_o;
  logic              vid_last_o;
  logic              vid_done_o;
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [31:0]       cpu_wdata_i;
  logic [3:0]        cpu_be_i;
  logic [31:0]       cpu_rdata_o;
  logic              cpu_ack_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic              mem_burst_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_be_o;
  logic              mem_ack_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;
  logic              mem_done_i;

  int n_cmp = 0;
  int n_mis = 0;
  int n_vid_done = 0;
  int n_cpu_ack = 0;
  int e_vid_done = 0;
  int e_cpu_ack = 0;

  cmd_t  exp_cmd_q[$];
  beat_t exp_beat_q[$];

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_W        (ADDR_W),
    .BURST_LEN     (BURST_LEN),
    .VID_MAX_CONSEC(VID_MAX_CONSEC)
  ) u_dut (
    .clk         (clk),
    .reset_i     (reset_i),
    .vid_req_i   (vid_req_i),
    .vid_addr_i  (vid_addr_i),
    .vid_valid_o (vid_valid_o),
    .vid_data_o  (vid_data_o),
    .vid_last_o  (vid_last_o),
    .vid_done_o  (vid_done_o),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_be_i    (cpu_be_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_ack_o   (cpu_ack_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_burst_o (mem_burst_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_done_i  (mem_done_i)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic we, input logic burst, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    cmd_t c;
    c.we    = we;
    c.burst = burst;
    c.addr  = addr;
    c.wdata = wdata;
    c.be    = be;
    exp_cmd_q.push_back(c);
  endtask

  // Every forwarded beat must match the next expected one; pulses are counted.
  always @(negedge clk) begin
    if (vid_done_o) n_vid_done++;
    if (cpu_ack_o) n_cpu_ack++;
    if (vid_valid_o) begin
      if (exp_beat_q.size() == 0) begin
        check_eq("vid_beat_unexpected", 64'(vid_valid_o), 64'd0);
      end else begin
        beat_t b;
        b = exp_beat_q.pop_front();
        check_eq("vid_beat", 64'({vid_data_o, vid_last_o}), 64'(b));
      end
    end
  end

  // Waits for the next command and acts as the controller for it.
  task automatic run_txn(input int nbeats, input logic [31:0] base, input bit ack_done,
                         input bit drop);
    cmd_t e;
    bit   vid;
    for (int i = 0; i < 40 && !mem_req_o; i++) tick();
    check_eq("req_seen", 64'(mem_req_o), 64'd1);
    e = '0;
    if (exp_cmd_q.size() != 0) e = exp_cmd_q.pop_front();
    vid = e.burst;
    check_eq("cmd", 64'({mem_we_o, mem_burst_o, mem_addr_o, mem_wdata_o, mem_be_o}), 64'(e));
    tick();
    check_eq("cmd_hold", 64'({mem_req_o, mem_addr_o}), 64'({1'b1, e.addr}));
    mem_ack_i  = 1'b1;
    mem_done_i = ack_done;
    tick();
    mem_ack_i  = 1'b0;
    mem_done_i = 1'b0;
    check_eq("req_drop", 64'(mem_req_o), 64'd0);
    if (!ack_done) begin
      for (int i = 0; i < nbeats; i++) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = base + 32'(i);
        if (vid && i < int'(BURST_LEN)) begin
          beat_t b;
          b.data = base + 32'(i);
          b.last = (i == int'(BURST_LEN) - 1);
          exp_beat_q.push_back(b);
        end
        tick();
      end
      mem_rvalid_i = 1'b0;
      check_eq("no_early_done", 64'(vid ? vid_done_o : cpu_ack_o), 64'd0);
      mem_done_i = 1'b1;
      tick();
      mem_done_i = 1'b0;
    end else begin
      check_eq("no_early_done", 64'(vid ? vid_done_o : cpu_ack_o), 64'd0);
      tick();
    end
    check_eq(vid ? "vid_done" : "cpu_ack", 64'(vid ? vid_done_o : cpu_ack_o), 64'd1);
    check_eq("other_quiet", 64'(vid ? cpu_ack_o : vid_done_o), 64'd0);
    if (vid) e_vid_done++;
    else e_cpu_ack++;
    if (!vid && !e.we) check_eq("cpu_rdata", 64'(cpu_rdata_o), 64'(base));
    if (drop) begin
      vid_req_i = 1'b0;
      cpu_req_i = 1'b0;
    end
    tick();
    check_eq("pulse_one_cycle", 64'(vid_done_o | cpu_ack_o), 64'd0);
    if (!vid && !e.we) check_eq("cpu_rdata_hold", 64'(cpu_rdata_o), 64'(base));
  endtask

  task automatic cpu_start(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    cpu_be_i    = be;
    push_cmd(we, 1'b0, addr, wdata, be);
  endtask

  task automatic vid_start(input logic [ADDR_W-1:0] addr);
    vid_req_i  = 1'b1;
    vid_addr_i = addr;
    push_cmd(1'b0, 1'b1, addr, 32'h0, 4'hF);
  endtask

  initial begin
    reset_i      = 1'b1;
    vid_req_i    = 1'b0;
    vid_addr_i   = '0;
    cpu_req_i    = 1'b0;
    cpu_we_i     = 1'b0;
    cpu_addr_i   = '0;
    cpu_wdata_i  = '0;
    cpu_be_i     = '0;
    mem_ack_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_done_i   = 1'b0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_mem_req", 64'(mem_req_o), 64'd0);
    check_eq("rst_cmd", 64'({mem_we_o, mem_burst_o, mem_addr_o, mem_wdata_o, mem_be_o}), 64'd0);
    check_eq("rst_pulses", 64'({vid_done_o, cpu_ack_o, vid_valid_o}), 64'd0);
    check_eq("rst_rdata", 64'(cpu_rdata_o), 64'd0);
    reset_i = 1'b0;
    tick();

    // CPU write alone, one-cycle grant latency
    cpu_start(1'b1, 24'h000100, 32'hDEADBEEF, 4'b0011);
    check_eq("cpu_wr_pre", 64'(mem_req_o), 64'd0);
    tick();
    check_eq("cpu_wr_lat", 64'(mem_req_o), 64'd1);
    run_txn(0, 32'h0, 1'b0, 1'b1);

    // Video burst
    vid_start(24'h040000);
    tick();
    check_eq("vid_lat", 64'(mem_req_o), 64'd1);
    run_txn(8, 32'hA000_0000, 1'b0, 1'b1);

    // Video burst with two surplus beats that must be dropped
    vid_start(24'h040100);
    run_txn(10, 32'hB000_0000, 1'b0, 1'b1);

    // CPU read
    cpu_start(1'b0, 24'h000200, 32'h0, 4'hF);
    run_txn(1, 32'h12345678, 1'b0, 1'b1);

    // Ack and done together in CMD
    cpu_start(1'b1, 24'h000400, 32'hCAFEF00D, 4'b1100);
    run_txn(0, 32'h0, 1'b1, 1'b1);
    repeat (3) tick();
    check_eq("no_dup_grant", 64'(mem_req_o), 64'd0);

    // Both requesters held: V,V,V,C repeating
    vid_req_i   = 1'b1;
    vid_addr_i  = 24'h050000;
    cpu_req_i   = 1'b1;
    cpu_we_i    = 1'b1;
    cpu_addr_i  = 24'h000500;
    cpu_wdata_i = 32'h55AA55AA;
    cpu_be_i    = 4'hF;
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3) push_cmd(1'b1, 1'b0, 24'h000500, 32'h55AA55AA, 4'hF);
      else push_cmd(1'b0, 1'b1, 24'h050000, 32'h0, 4'hF);
    end
    for (int k = 0; k < 8; k++) begin
      run_txn((k % 4 == 3) ? 0 : 8, 32'hC000_0000 + 32'(k * 16), 1'b0, k == 7);
    end

    // Reset in WAIT after three beats of a burst
    vid_start(24'h080000);
    for (int i = 0; i < 40 && !mem_req_o; i++) tick();
    check_eq("rst_mid_req_seen", 64'(mem_req_o), 64'd1);
    begin
      cmd_t e;
      e = '0;
      if (exp_cmd_q.size() != 0) e = exp_cmd_q.pop_front();
      check_eq("rst_mid_cmd",
               64'({mem_we_o, mem_burst_o, mem_addr_o, mem_wdata_o, mem_be_o}), 64'(e));
    end
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat_t b;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hD000_0000 + 32'(i);
      b.data = mem_rdata_i;
      b.last = 1'b0;
      exp_beat_q.push_back(b);
      tick();
    end
    mem_rvalid_i = 1'b0;
    reset_i      = 1'b1;
    tick();
    reset_i   = 1'b0;
    vid_req_i = 1'b0;
    check_eq("rst_mid_req", 64'(mem_req_o), 64'd0);
    check_eq("rst_mid_rdata", 64'(cpu_rdata_o), 64'd0);
    for (int i = 3; i < 8; i++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hD000_0000 + 32'(i);
      tick();
    end
    mem_rvalid_i = 1'b0;
    mem_done_i   = 1'b1;
    tick();
    mem_done_i = 1'b0;
    check_eq("rst_mid_no_done", 64'(vid_done_o), 64'd0);
    tick();
    check_eq("rst_mid_idle", 64'({mem_req_o, vid_done_o}), 64'd0);

    // Normal grant after the abandoned burst
    cpu_start(1'b1, 24'h000300, 32'h0BADF00D, 4'b0101);
    tick();
    check_eq("post_rst_lat", 64'(mem_req_o), 64'd1);
    run_txn(0, 32'h0, 1'b0, 1'b1);
    repeat (2) tick();

    check_eq("vid_done_count", 64'(n_vid_done), 64'(e_vid_done));
    check_eq("cpu_ack_count", 64'(n_cpu_ack), 64'(e_cpu_ack));
    check_eq("beats_left", 64'(exp_beat_q.size()), 64'd0);
    check_eq("cmds_left", 64'(exp_cmd_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 24: word address width toward the SDRAM controller.
REQ-002 Parameter BURST_LEN, 8: 32-bit beats per video burst read.
REQ-003 Parameter VID_MAX_CONSEC, 3: video grants allowed back-to-back while CPU waits.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 vid_req_i  in  1  video burst read request; held until vid_done_o.
REQ-007 vid_addr_i  in  ADDR_W  video burst start address.
REQ-008 vid_valid_o / vid_data_o  out  1 / 32  video read beat strobe and data.
REQ-009 vid_last_o / vid_done_o  out  1 / 1  final-beat flag; transaction-complete pulse.
REQ-010 cpu_req_i / cpu_we_i  in  1 / 1  CPU single-word request and direction; held until cpu_ack_o.
REQ-011 cpu_addr_i / cpu_wdata_i / cpu_be_i  in  ADDR_W / 32 / 4  CPU address, write data, byte enables.
REQ-012 cpu_rdata_o / cpu_ack_o  out  32 / 1  CPU read data; completion pulse.
REQ-013 mem_req_o / mem_we_o / mem_burst_o  out  1 / 1 / 1  command to controller; burst=1 means BURST_LEN-beat read.
REQ-014 mem_addr_o / mem_wdata_o / mem_be_o  out  ADDR_W / 32 / 4  command address, write data, byte enables.
REQ-015 mem_ack_i / mem_rvalid_i / mem_rdata_i / mem_done_i  in  1 / 1 / 32 / 1  command accepted, read beat valid, read data, transaction complete.

Function
REQ-016 FSM states SHALL be IDLE, CMD, WAIT; owner register SHALL be NONE, VID or CPU.
REQ-017 IDLE: on any request, the owner SHALL be registered and the FSM SHALL enter CMD; mem_req_o SHALL be high in the following cycle (one-cycle grant latency).
REQ-018 Simultaneous requests SHALL grant VID unless the starvation counter equals VID_MAX_CONSEC, in which case they SHALL grant CPU.
REQ-019 The starvation counter SHALL increment on each VID grant while cpu_req_i is high, clear on each CPU grant, clear when cpu_req_i is low at a VID grant, and saturate at VID_MAX_CONSEC.
REQ-020 CMD: mem_req_o and all mem_* command fields SHALL be registered from the owner's inputs and held stable until mem_ack_i; on mem_ack_i the FSM SHALL move to WAIT and mem_req_o SHALL drop the next cycle.
REQ-021 VID commands SHALL drive mem_we_o=0, mem_burst_o=1, mem_be_o=4'hF; CPU commands SHALL drive mem_burst_o=0 and their own we/be/wdata.
REQ-022 When the owner is VID, vid_valid_o SHALL equal mem_rvalid_i and vid_data_o SHALL equal mem_rdata_i combinationally (zero latency); vid_valid_o SHALL be 0 otherwise.
REQ-023 A beat counter SHALL count VID beats from 0; vid_last_o SHALL be high with the beat at which the count equals BURST_LEN-1; beats after the final one SHALL be dropped.
REQ-024 When the owner is CPU, cpu_rdata_o SHALL capture mem_rdata_i on mem_rvalid_i and hold it until the next CPU read capture.
REQ-025 WAIT: on mem_done_i, the owner's done/ack SHALL pulse for exactly one cycle (registered, next cycle), the owner SHALL return to NONE and the FSM to IDLE; a new grant SHALL not occur before that IDLE cycle.
REQ-026 mem_rvalid_i and mem_done_i received in IDLE or CMD SHALL be ignored.
REQ-027 mem_ack_i and mem_done_i in the same cycle while in CMD SHALL be treated as ack followed by done, completing the transaction one cycle later.

Reset
REQ-028 While reset_i is high at a clock edge: FSM=IDLE, owner=NONE, starvation and beat counters=0, mem_req_o=0, vid_done_o=0, cpu_ack_o=0, cpu_rdata_o=0, all mem_* command outputs=0.
REQ-029 Reset during CMD or WAIT SHALL abandon the transaction without generating ack/done; responses still arriving from the controller SHALL be ignored under REQ-026.

Structure
REQ-030 Package sdram_arb_pkg SHALL hold the state and owner enum typedefs and the default BURST_LEN constant.
REQ-031 The block SHALL be a single module with no sub-modules; the starvation counter and beat counter SHALL be inline.

Verification
REQ-032 CPU write alone, addr 24'h000100, data 32'hDEADBEEF, be 4'b0011 -> mem_req_o high one cycle later with those fields; done -> cpu_ack_o pulses once.
REQ-033 Video burst at 24'h040000 -> mem_burst_o=1, 8 vid_valid_o beats, vid_last_o on the 8th beat only, vid_done_o pulses once.
REQ-034 vid_req_i and cpu_req_i held continuously -> grants V,V,V,C,V,V,V,C repeat.
REQ-035 CPU read returning 32'h12345678 -> cpu_rdata_o=32'h12345678 when cpu_ack_o is high and afterwards; vid_valid_o stays 0 throughout.
REQ-036 reset_i asserted in WAIT mid-burst after 3 beats -> no vid_done_o; remaining beats are not forwarded; the next request is granted normally.
REQ-037 mem_ack_i and mem_done_i high together in CMD -> single ack/done pulse; return to IDLE with no lost or duplicated grant.
